// File: rtl/cop_perfcnt_pkg.sv
// Shared constants and types for the coprocessor performance-counter bank.
// Counter indices, control-register map and PERFCTL field layout.
package perf_pkg;

  localparam int NUM_CNT   = 8;
  localparam int CNT_IDX_W = 3;
  localparam int DATA_W    = 32;

  // General-register index of each counter
  localparam logic [4:0] PC_INST   = 5'd0;
  localparam logic [4:0] PC_IMISS  = 5'd1;
  localparam logic [4:0] PC_ISTALL = 5'd2;
  localparam logic [4:0] PC_DMISS  = 5'd3;
  localparam logic [4:0] PC_DSTALL = 5'd4;
  localparam logic [4:0] PC_DLOAD  = 5'd5;
  localparam logic [4:0] PC_DSTORE = 5'd6;
  localparam logic [4:0] PC_CYCLE  = 5'd7;

  // Control-register indices
  localparam logic [4:0] PERFCTL = 5'd0;
  localparam logic [4:0] PERFOVF = 5'd1;

  // PERFCTL bit positions
  localparam int EN_LSB    = 0;
  localparam int OVFIE_BIT = 8;
  localparam int FRZ_BIT   = 9;
  localparam int CTL_W     = 10;

  // Packed so that frz lands on bit 9, ovfie on bit 8 and en on [7:0]
  typedef struct packed {
    logic               frz;
    logic               ovfie;
    logic [NUM_CNT-1:0] en;
  } perfctl_t;

  function automatic perfctl_t to_perfctl(input logic [DATA_W-1:0] data);
    return perfctl_t'(data[CTL_W-1:0]);
  endfunction

endpackage

// File: rtl/cop_perfcnt_if.sv
// Coprocessor-side bundle for the performance-counter bank: event strobes,
// CRD/CWR register ports and the condition/interrupt outputs.
interface cop_perfcnt_if;

  logic        CNTINST;
  logic        CNTIMISS;
  logic        CNTISTALL;
  logic        CNTDMISS;
  logic        CNTDSTALL;
  logic        CNTDLOAD;
  logic        CNTDSTORE;

  logic [4:0]  CRDADDR;
  logic        CRDGEN;
  logic        CRDCON;
  logic [31:0] CRDDATA;

  logic [4:0]  CWRADDR;
  logic        CWRGEN;
  logic        CWRCON;
  logic [31:0] CWRDATA;

  logic        CONDINN;
  logic        PERFINT;

  modport master (
    output CNTINST, CNTIMISS, CNTISTALL, CNTDMISS, CNTDSTALL, CNTDLOAD, CNTDSTORE,
    output CRDADDR, CRDGEN, CRDCON,
    output CWRADDR, CWRGEN, CWRCON, CWRDATA,
    input  CRDDATA, CONDINN, PERFINT
  );

  modport slave (
    input  CNTINST, CNTIMISS, CNTISTALL, CNTDMISS, CNTDSTALL, CNTDLOAD, CNTDSTORE,
    input  CRDADDR, CRDGEN, CRDCON,
    input  CWRADDR, CWRGEN, CWRCON, CWRDATA,
    output CRDDATA, CONDINN, PERFINT
  );

endinterface

// File: rtl/cop_perfcnt_counter.sv
// Single wrapping event counter with software load; wrap pulses high in the
// cycle whose increment rolls the counter from all-ones back to zero.
module perf_counter32 #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // A load in the same cycle as an increment suppresses both count and wrap
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_data;
    end else if (inc) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign wrap  = inc & ~load & (&count_reg);

endmodule

// File: rtl/cop_perfcnt.sv
// Performance-counter register bank: eight counters, PERFCTL/PERFOVF control
// registers, combinational read mux, condition line and overflow interrupt.
module cop_perfcnt
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         SYSCLK,
  input  logic         RESET_D1_R,
  cop_perfcnt_if.slave bus
);

  logic [NUM_CNT-1:0] event_vec;
  logic [NUM_CNT-1:0] inc_vec;
  logic [NUM_CNT-1:0] load_vec;
  logic [NUM_CNT-1:0] wrap_vec;
  logic [CNT_W-1:0]   count_arr [NUM_CNT];

  perfctl_t           ctl_reg;
  perfctl_t           ctl_next;
  logic [NUM_CNT-1:0] ovf_reg;
  logic [NUM_CNT-1:0] ovf_next;
  logic [NUM_CNT-1:0] ovf_clr;
  logic               perfint_reg;
  logic               perfint_next;

  logic               frozen;
  logic               gen_wr;
  logic               con_wr;
  logic [DATA_W-1:0]  rd_data;

  // CYCLE has no strobe of its own; it counts whenever enabled
  assign event_vec = {1'b1,
                      bus.CNTDSTORE, bus.CNTDLOAD, bus.CNTDSTALL,
                      bus.CNTDMISS, bus.CNTISTALL, bus.CNTIMISS, bus.CNTINST};

  assign frozen = ctl_reg.frz & (|ovf_reg);

  // A GEN write takes priority and blocks a simultaneous CON write
  assign gen_wr = bus.CWRGEN;
  assign con_wr = bus.CWRCON & ~bus.CWRGEN;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      assign inc_vec[gi]  = ctl_reg.en[gi] & event_vec[gi] & ~frozen;
      assign load_vec[gi] = gen_wr & (bus.CWRADDR == 5'(gi));

      perf_counter32 #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk       (SYSCLK),
        .srst      (RESET_D1_R),
        .inc       (inc_vec[gi]),
        .load      (load_vec[gi]),
        .load_data (bus.CWRDATA[CNT_W-1:0]),
        .count     (count_arr[gi]),
        .wrap      (wrap_vec[gi])
      );
    end
  endgenerate

  // New overflows are OR-ed in after the W1C mask so a same-cycle set wins
  always_comb begin
    ctl_next = ctl_reg;
    ovf_clr  = '0;
    if (con_wr && (bus.CWRADDR == PERFCTL)) begin
      ctl_next = to_perfctl(bus.CWRDATA);
    end
    if (con_wr && (bus.CWRADDR == PERFOVF)) begin
      ovf_clr = bus.CWRDATA[NUM_CNT-1:0];
    end
    ovf_next     = (ovf_reg & ~ovf_clr) | wrap_vec;
    perfint_next = ctl_reg.ovfie & (|ovf_next);
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      ctl_reg     <= '0;
      ovf_reg     <= '0;
      perfint_reg <= 1'b0;
    end else begin
      ctl_reg     <= ctl_next;
      ovf_reg     <= ovf_next;
      perfint_reg <= perfint_next;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.CRDGEN) begin
      if (bus.CRDADDR < 5'(NUM_CNT)) begin
        rd_data = DATA_W'(count_arr[bus.CRDADDR[CNT_IDX_W-1:0]]);
      end
    end else if (bus.CRDCON) begin
      if (bus.CRDADDR == PERFCTL) begin
        rd_data = DATA_W'(ctl_reg);
      end else if (bus.CRDADDR == PERFOVF) begin
        rd_data = DATA_W'(ovf_reg);
      end
    end
  end

  assign bus.CRDDATA = rd_data;
  assign bus.CONDINN = ~(|ovf_reg);
  assign bus.PERFINT = perfint_reg;

endmodule
